hwpe_tcdm_arb_mux: RTL

HWPE_TCDM_ARB_MUX -- requirements
Module: hwpe_tcdm_arb_mux

---
 rtl/hwpe_tcdm_arb_pkg.sv | 20 ++
 rtl/hwpe_tcdm_resp_fifo.sv | 64 ++++++
 rtl/hwpe_tcdm_arb_mux.sv | 127 ++++++++++++
 3 files changed

// File: rtl/hwpe_tcdm_arb_pkg.sv
// Shared types and helpers for the HWPE TCDM arbiter/mux and its response-tracking FIFO.
package hwpe_tcdm_arb_pkg;

    localparam int unsigned ARB_N_PORTS_DEF         = 32'd3;
    localparam int unsigned ARB_MAX_OUTSTANDING_DEF = 32'd4;

    // $clog2 that never returns 0, so single-entry ranges still get a 1-bit index
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned w;
        w = $clog2(n);
        return (w == 32'd0) ? 32'd1 : w;
    endfunction

    localparam int unsigned PORT_IDX_W = clog2_min1(ARB_N_PORTS_DEF);
    localparam int unsigned FIFO_CNT_W = $clog2(ARB_MAX_OUTSTANDING_DEF + 32'd1);

    typedef logic [PORT_IDX_W-1:0] port_idx_t;
    typedef logic [FIFO_CNT_W-1:0] fifo_cnt_t;

endpackage

// File: rtl/hwpe_tcdm_resp_fifo.sv
// Response-tracking FIFO: remembers which upstream port owns each granted, still unanswered transaction.
module hwpe_tcdm_resp_fifo
    import hwpe_tcdm_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32'd2,
    parameter int unsigned DEPTH      = 32'd4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned PTR_W = clog2_min1(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 32'd1);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [CNT_W-1:0]      count_r;
    logic                  do_push_s;
    logic                  do_pop_s;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 32'd1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
    endfunction

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;
    assign data_out  = mem_r[rd_ptr_r];

    // Storage array; contents are don't-care while empty, so it carries no reset
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= data_in;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves the count unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_r <= do_push_s ? next_ptr(wr_ptr_r) : wr_ptr_r;
            rd_ptr_r <= do_pop_s  ? next_ptr(rd_ptr_r) : rd_ptr_r;
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/hwpe_tcdm_arb_mux.sv
// N-to-1 TCDM arbiter/mux with in-order response routing back to the issuing port.
// Define HWPE_TCDM_ARB_RR_EN for round-robin selection; otherwise the lowest requesting index wins.
module hwpe_tcdm_arb_mux
    import hwpe_tcdm_arb_pkg::*;
#(
    parameter int unsigned N_PORTS         = ARB_N_PORTS_DEF,
    parameter int unsigned ADDR_WIDTH      = 32'd32,
    parameter int unsigned DATA_WIDTH      = 32'd32,
    parameter int unsigned MAX_OUTSTANDING = ARB_MAX_OUTSTANDING_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_PORTS-1:0]              in_req,
    output logic [N_PORTS-1:0]              in_gnt,
    input  logic [N_PORTS*ADDR_WIDTH-1:0]   in_add,
    input  logic [N_PORTS-1:0]              in_wen,
    input  logic [N_PORTS*DATA_WIDTH/8-1:0] in_be,
    input  logic [N_PORTS*DATA_WIDTH-1:0]   in_data,
    output logic [N_PORTS*DATA_WIDTH-1:0]   in_r_data,
    output logic [N_PORTS-1:0]              in_r_valid,
    output logic                            out_req,
    output logic [ADDR_WIDTH-1:0]           out_add,
    output logic                            out_wen,
    output logic [DATA_WIDTH/8-1:0]         out_be,
    output logic [DATA_WIDTH-1:0]           out_data,
    input  logic                            out_gnt,
    input  logic [DATA_WIDTH-1:0]           out_r_data,
    input  logic                            out_r_valid,
    output logic                            err
);

    localparam int unsigned IDX_W = clog2_min1(N_PORTS);
    localparam int unsigned BE_W  = DATA_WIDTH / 32'd8;

    logic [IDX_W-1:0] sel_s;
    logic [IDX_W-1:0] head_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic             xfer_s;
    logic             pop_s;
    logic             err_r;

`ifdef HWPE_TCDM_ARB_RR_EN
    logic [IDX_W-1:0] rr_ptr_r;

    // Round-robin pick: first requester at or after rr_ptr_r, wrapping modulo N_PORTS
    always_comb begin : rr_sel_p
        int   j;
        logic found_s;
        sel_s   = {IDX_W{1'b0}};
        found_s = 1'b0;
        j       = 0;
        for (int k = 0; k < int'(N_PORTS); k++) begin
            j = int'(rr_ptr_r) + k;
            j = (j >= int'(N_PORTS)) ? j - int'(N_PORTS) : j;
            sel_s   = (!found_s && in_req[j]) ? IDX_W'(j) : sel_s;
            found_s = found_s | in_req[j];
        end
    end

    // Pointer moves just past the winner only when a transaction actually transfers
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_r <= {IDX_W{1'b0}};
        end else if (xfer_s) begin
            rr_ptr_r <= (sel_s == IDX_W'(N_PORTS - 32'd1)) ? {IDX_W{1'b0}} : sel_s + IDX_W'(1);
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end
`else
    // Fixed priority: scanning downwards leaves the lowest requesting index selected
    always_comb begin
        sel_s = {IDX_W{1'b0}};
        for (int k = int'(N_PORTS) - 1; k >= 0; k--) begin
            sel_s = in_req[k] ? IDX_W'(k) : sel_s;
        end
    end
`endif

    // A full tracker blocks new requests even if a response frees an entry this cycle
    assign out_req = (|in_req) & ~fifo_full_s & ~rst;
    assign xfer_s  = out_req & out_gnt;
    assign pop_s   = out_r_valid & ~fifo_empty_s & ~rst;

    // Forward the selected port's request fields and steer grant / response valid
    always_comb begin
        out_add    = in_add[int'(sel_s)*int'(ADDR_WIDTH) +: ADDR_WIDTH];
        out_wen    = in_wen[sel_s];
        out_be     = in_be[int'(sel_s)*int'(BE_W) +: BE_W];
        out_data   = in_data[int'(sel_s)*int'(DATA_WIDTH) +: DATA_WIDTH];
        in_gnt     = {N_PORTS{1'b0}};
        in_gnt[sel_s] = xfer_s;
        in_r_valid = {N_PORTS{1'b0}};
        in_r_valid[head_s] = pop_s;
    end

    assign in_r_data = {N_PORTS{out_r_data}};

    // A response with nothing outstanding is an orphan; flag it until reset
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (out_r_valid && fifo_empty_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign err = err_r;

    hwpe_tcdm_resp_fifo #(
        .DATA_WIDTH (IDX_W),
        .DEPTH      (MAX_OUTSTANDING)
    ) u_resp_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (xfer_s),
        .pop      (pop_s),
        .data_in  (sel_s),
        .data_out (head_s),
        .full     (fifo_full_s),
        .empty    (fifo_empty_s)
    );

endmodule
